// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: register-select encodings and default pin count.
package gpio_pkg;

    localparam int unsigned GPIO_DEFAULT_WIDTH = 8;

    typedef enum logic [2:0] {
        GPIO_OUT      = 3'd0,
        GPIO_OUT_SET  = 3'd1,
        GPIO_OUT_CLR  = 3'd2,
        GPIO_OUT_TGL  = 3'd3,
        GPIO_DIR      = 3'd4,
        GPIO_IN       = 3'd5,
        GPIO_IRQ_EN   = 3'd6,
        GPIO_IRQ_PEND = 3'd7
    } gpio_addr_e;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser bringing asynchronous pad inputs into the clk domain.
module gpio_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: output register with atomic set/clear/toggle, direction register,
// synchronised inputs and per-pin any-edge interrupts with W1C pending bits.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = GPIO_DEFAULT_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    gpio_addr_e       reg_sel;
    logic [WIDTH-1:0] out_q,  out_d;
    logic [WIDTH-1:0] dir_q,  dir_d;
    logic [WIDTH-1:0] en_q,   en_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] in_s;
    logic [WIDTH-1:0] chg;
    logic [WIDTH-1:0] pend_clr;

    assign reg_sel = gpio_addr_e'(addr);

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (gpio_in),
        .q_o   (in_s)
    );

    assign chg = in_s ^ prev_q;

    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        en_d     = en_q;
        pend_clr = '0;
        if (we) begin
            case (reg_sel)
                GPIO_OUT:      out_d    = wdata;
                GPIO_OUT_SET:  out_d    = out_q | wdata;
                GPIO_OUT_CLR:  out_d    = out_q & ~wdata;
                GPIO_OUT_TGL:  out_d    = out_q ^ wdata;
                GPIO_DIR:      dir_d    = wdata;
                GPIO_IRQ_EN:   en_d     = wdata;
                GPIO_IRQ_PEND: pend_clr = wdata;
                default:       ;
            endcase
        end
        // Hardware set is OR-ed in after the clear so a same-cycle edge wins.
        pend_d = (pend_q & ~pend_clr) | (chg & en_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            dir_q  <= '0;
            en_q   <= '0;
            pend_q <= '0;
            prev_q <= '0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            en_q   <= en_d;
            pend_q <= pend_d;
            prev_q <= in_s;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            GPIO_OUT, GPIO_OUT_SET,
            GPIO_OUT_CLR, GPIO_OUT_TGL: rdata = out_q;
            GPIO_DIR:                   rdata = dir_q;
            GPIO_IN:                    rdata = in_s;
            GPIO_IRQ_EN:                rdata = en_q;
            GPIO_IRQ_PEND:              rdata = pend_q;
            default:                    rdata = '0;
        endcase
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |pend_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: directed vector table, reset corner cases,
// and randomized traffic against a history-based reference model.
module tb_gpio_bank;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   addr = '0;
    logic         we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] rdata;
    logic [W-1:0] gpio_in = '0;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic         irq;

    always #5 clk = ~clk;

    gpio_bank #(
        .WIDTH       (W),
        .SYNC_STAGES (S)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .we       (we),
        .wdata    (wdata),
        .rdata    (rdata),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: IN is the pad value sampled S edges ago; hist[0] is newest sample.
    logic [W-1:0] m_out, m_dir, m_en, m_pend;
    logic [W-1:0] hist[$];

    function automatic void m_reset();
        m_out = '0; m_dir = '0; m_en = '0; m_pend = '0;
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back('0);
    endfunction

    function automatic logic [W-1:0] m_read(input logic [2:0] a);
        case (a)
            3'd0, 3'd1, 3'd2, 3'd3: return m_out;
            3'd4: return m_dir;
            3'd5: return hist[S-1];
            3'd6: return m_en;
            default: return m_pend;
        endcase
    endfunction

    function automatic void m_edge();
        logic [W-1:0] newly;
        logic [W-1:0] clr;
        newly = (hist[S-1] ^ hist[S]) & m_en;
        clr = '0;
        if (we) begin
            case (addr)
                3'd0: m_out = wdata;
                3'd1: m_out = m_out | wdata;
                3'd2: m_out = m_out & ~wdata;
                3'd3: m_out = m_out ^ wdata;
                3'd4: m_dir = wdata;
                3'd6: m_en  = wdata;
                3'd7: clr   = wdata;
                default: ;
            endcase
        end
        m_pend = (m_pend & ~clr) | newly;
        hist.push_front(gpio_in);
        void'(hist.pop_back());
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        m_edge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]   a;
        logic         w;
        logic [W-1:0] wd;
        logic [W-1:0] gin;
        logic [W-1:0] e_out;
        logic [W-1:0] e_oe;
        logic         e_irq;
        logic [W-1:0] e_rd;
    } vec_t;

    vec_t vt[$];

    initial begin
        // addr, we, wdata, gpio_in | gpio_out, gpio_oe, irq, rdata (after the edge)
        vt.push_back('{3'd0, 1'b1, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b0, 8'hA5});
        vt.push_back('{3'd1, 1'b1, 8'h0F, 8'h00, 8'hAF, 8'h00, 1'b0, 8'hAF});
        vt.push_back('{3'd2, 1'b1, 8'h81, 8'h00, 8'h2E, 8'h00, 1'b0, 8'h2E});
        vt.push_back('{3'd3, 1'b1, 8'hFF, 8'h00, 8'hD1, 8'h00, 1'b0, 8'hD1});
        vt.push_back('{3'd4, 1'b1, 8'hF0, 8'h00, 8'hD1, 8'hF0, 1'b0, 8'hF0});
        vt.push_back('{3'd5, 1'b1, 8'h55, 8'h00, 8'hD1, 8'hF0, 1'b0, 8'h00});
        vt.push_back('{3'd6, 1'b1, 8'h01, 8'h00, 8'hD1, 8'hF0, 1'b0, 8'h01});
        vt.push_back('{3'd5, 1'b0, 8'h00, 8'h01, 8'hD1, 8'hF0, 1'b0, 8'h00});
        vt.push_back('{3'd5, 1'b0, 8'h00, 8'h01, 8'hD1, 8'hF0, 1'b0, 8'h01});
        vt.push_back('{3'd7, 1'b0, 8'h00, 8'h01, 8'hD1, 8'hF0, 1'b1, 8'h01});
        vt.push_back('{3'd7, 1'b1, 8'h01, 8'h01, 8'hD1, 8'hF0, 1'b0, 8'h00});
        vt.push_back('{3'd6, 1'b1, 8'h00, 8'h01, 8'hD1, 8'hF0, 1'b0, 8'h00});
        vt.push_back('{3'd5, 1'b0, 8'h00, 8'h00, 8'hD1, 8'hF0, 1'b0, 8'h01});
        vt.push_back('{3'd5, 1'b0, 8'h00, 8'h00, 8'hD1, 8'hF0, 1'b0, 8'h00});
        vt.push_back('{3'd7, 1'b0, 8'h00, 8'h00, 8'hD1, 8'hF0, 1'b0, 8'h00});
        vt.push_back('{3'd6, 1'b1, 8'h02, 8'h02, 8'hD1, 8'hF0, 1'b0, 8'h02});
        vt.push_back('{3'd5, 1'b0, 8'h00, 8'h02, 8'hD1, 8'hF0, 1'b0, 8'h02});
        vt.push_back('{3'd7, 1'b0, 8'h00, 8'h02, 8'hD1, 8'hF0, 1'b1, 8'h02});
        vt.push_back('{3'd7, 1'b1, 8'h02, 8'h00, 8'hD1, 8'hF0, 1'b0, 8'h00});
        vt.push_back('{3'd5, 1'b0, 8'h00, 8'h00, 8'hD1, 8'hF0, 1'b0, 8'h00});
        vt.push_back('{3'd7, 1'b0, 8'h00, 8'h00, 8'hD1, 8'hF0, 1'b1, 8'h02});
        vt.push_back('{3'd7, 1'b1, 8'h02, 8'h02, 8'hD1, 8'hF0, 1'b0, 8'h00});
        vt.push_back('{3'd7, 1'b0, 8'h00, 8'h02, 8'hD1, 8'hF0, 1'b0, 8'h00});
        vt.push_back('{3'd7, 1'b1, 8'h02, 8'h02, 8'hD1, 8'hF0, 1'b1, 8'h02});

        m_reset();
        #12;
        check("oe_in_reset", gpio_oe, 8'h00);
        check("out_in_reset", gpio_out, 8'h00);
        check("irq_in_reset", irq, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            addr = 3'(a);
            #1;
            check($sformatf("reset_read_%0d", a), rdata, 8'h00);
        end
        @(negedge clk);

        for (int i = 0; i < vt.size(); i++) begin
            addr = vt[i].a; we = vt[i].w; wdata = vt[i].wd; gpio_in = vt[i].gin;
            tick();
            check($sformatf("vec%0d_out", i), gpio_out, vt[i].e_out);
            check($sformatf("vec%0d_oe", i), gpio_oe, vt[i].e_oe);
            check($sformatf("vec%0d_irq", i), irq, vt[i].e_irq);
            check($sformatf("vec%0d_rdata", i), rdata, vt[i].e_rd);
        end

        for (int i = 0; i < 400; i++) begin
            addr  = 3'($urandom_range(0, 7));
            we    = 1'($urandom_range(0, 1));
            wdata = 8'($urandom);
            if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom);
            tick();
            check("rnd_out", gpio_out, m_out);
            check("rnd_oe", gpio_oe, m_dir);
            check("rnd_irq", irq, |m_pend);
            check("rnd_rdata", rdata, m_read(addr));
        end

        // Mid-operation asynchronous reset with outputs driven and interrupts pending.
        addr = 3'd0; we = 1'b1; wdata = 8'hFF; tick();
        addr = 3'd4; tick();
        addr = 3'd6; tick();
        we = 1'b0; gpio_in = ~gpio_in;
        tick(); tick(); tick();
        check("pre_rst_irq", irq, 1'b1);
        check("pre_rst_out", gpio_out, 8'hFF);
        check("pre_rst_oe", gpio_oe, 8'hFF);
        gpio_in = 8'hFF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_out", gpio_out, 8'h00);
        check("async_rst_oe", gpio_oe, 8'h00);
        check("async_rst_irq", irq, 1'b0);
        m_reset();
        addr = 3'd5;
        #1;
        check("async_rst_in", rdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_1", rdata, 8'h00);
        tick();
        check("post_rst_in_2", rdata, 8'hFF);
        check("post_rst_model", rdata, m_read(addr));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
